// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product MAC sequencer; optional start-while-busy error flag via MAC_SEQ_STARTERR_EN
module mac_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [15:0]       act_data,
  input  logic [15:0]       wgt_data,
  output logic [15:0]       mac_a,
  output logic [15:0]       mac_b,
  output logic              mac_output_en,
  input  logic [15:0]       mac_result,
  output logic              busy,
  output logic              res_valid,
  output logic [15:0]       res_data,
  input  logic              res_ready,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    FLUSH   = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic             rd_q;
  logic             accept;

  // A new job is taken from IDLE, or from OUT in the same cycle the result is handed off
  assign accept = start && ((state == IDLE) || ((state == OUT) && res_ready));

  assign rd_en         = (state == FETCH);
  assign mac_output_en = (state == DRAIN);
  assign busy          = (state != IDLE);
  assign res_valid     = (state == OUT);

  // Operands reach the MAC only on the cycle their read data is valid; zero otherwise
  assign mac_a = rd_q ? act_data : 16'h0000;
  assign mac_b = rd_q ? wgt_data : 16'h0000;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an accepted start always wins so back-to-back jobs skip IDLE
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (len == '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        FETCH:   if (rem == LEN_W'(1)) state_nxt = FLUSH;
        FLUSH:   state_nxt = DRAIN;
        DRAIN:   state_nxt = CAPTURE;
        CAPTURE: state_nxt = OUT;
        OUT:     if (res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Address walk, remaining-count, read-data-valid tracking and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_addr <= '0;
      wgt_addr <= '0;
      rem      <= '0;
      rd_q     <= 1'b0;
      res_data <= 16'h0000;
    end else begin
      rd_q <= rd_en;
      if (accept) begin
        act_addr <= act_base;
        wgt_addr <= wgt_base;
        rem      <= len;
      end else if (state == FETCH) begin
        act_addr <= act_addr + ADDR_W'(1);
        wgt_addr <= wgt_addr + ADDR_W'(1);
        rem      <= rem - LEN_W'(1);
      end
      if (state == CAPTURE) begin
        res_data <= mac_result;
      end
    end
  end

`ifdef MAC_SEQ_STARTERR_EN
  logic err_q;

  // Sticky flag for a start that arrived while a job was running and was dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start && busy && !accept) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl with behavioural operand memories and MAC
`timescale 1ns/1ps
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len = '0;
  logic [9:0]  act_base = '0;
  logic [9:0]  wgt_base = '0;
  logic        rd_en;
  logic [9:0]  act_addr, wgt_addr;
  logic [15:0] act_data = '0;
  logic [15:0] wgt_data = '0;
  logic [15:0] mac_a, mac_b;
  logic        mac_output_en;
  logic [15:0] mac_result = '0;
  logic        busy;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b1;
  logic        err;

  mac_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .act_base(act_base), .wgt_base(wgt_base), .rd_en(rd_en),
    .act_addr(act_addr), .wgt_addr(wgt_addr), .act_data(act_data), .wgt_data(wgt_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_output_en(mac_output_en), .mac_result(mac_result),
    .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; int cyc; } exp_t;
  typedef struct { logic [9:0] a; logic [9:0] w; } addr_t;

  exp_t        res_q[$];
  addr_t       addr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          drain_cnt = 0;
  logic [15:0] act_mem [0:1023];
  logic [15:0] wgt_mem [0:1023];
  logic [31:0] acc = '0;
  bit          prev_valid = 0;
  bit          prev_hs = 0;
  logic [15:0] held = '0;
`ifdef MAC_SEQ_STARTERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      act_data <= act_mem[act_addr];
      wgt_data <= wgt_mem[wgt_addr];
    end
  end

  // MAC model: full 32-bit products accumulate, drain returns bits 31:16 and clears
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mac_result <= '0;
    end else if (mac_output_en) begin
      mac_result <= acc[31:16];
      acc <= '0;
    end else begin
      acc <= acc + 32'(mac_a) * 32'(mac_b);
    end
  end

  // Monitor: addresses on every rd_en, results on every newly presented res_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      addr_q.delete();
      drain_cnt = 0;
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          check("unexpected_rd_en", 1, 0);
        end else begin
          addr_t e;
          e = addr_q.pop_front();
          check("act_addr", act_addr, e.a);
          check("wgt_addr", wgt_addr, e.w);
        end
      end
      if (mac_output_en) drain_cnt++;
      if (res_valid && (!prev_valid || prev_hs)) begin
        if (res_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = res_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_valid_cycle", cyc, e.cyc);
          check("drain_count", drain_cnt, 1);
        end
        drain_cnt = 0;
        held = res_data;
      end else if (res_valid) begin
        check("res_data_held", res_data, held);
      end
      prev_valid = res_valid;
      prev_hs = res_valid && res_ready;
    end
  end

  task automatic fill(input int base, input int n, input logic [15:0] av, input int wbase, input logic [15:0] wv);
    for (int k = 0; k < n; k++) begin
      act_mem[(base + k) % 1024] = av;
      wgt_mem[(wbase + k) % 1024] = wv;
    end
  endtask

  task automatic push_job(input int l, input logic [9:0] ab, input logic [9:0] wb, input logic [15:0] ed, input bit want);
    exp_t e;
    addr_t a;
    if (want) begin
      e.data = ed;
      e.cyc = cyc + ((l == 0) ? 3 : l + 4);
      res_q.push_back(e);
    end
    for (int k = 0; k < l; k++) begin
      a.a = ab + 10'(k);
      a.w = wb + 10'(k);
      addr_q.push_back(a);
    end
  endtask

  task automatic issue(input int l, input logic [9:0] ab, input logic [9:0] wb, input logic [15:0] ed, input bit want);
    @(posedge clk); #2;
    start = 1'b1;
    len = 10'(l);
    act_base = ab;
    wgt_base = wb;
    push_job(l, ab, wb, ed, want);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (!busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = '0;
      wgt_mem[i] = '0;
    end
    fill(10'h010, 4, 16'h0200, 10'h100, 16'h0300);
    fill(10'h3FE, 4, 16'h0100, 10'h200, 16'h0100);
    fill(10'h040, 2, 16'h0200, 10'h140, 16'h0500);
    fill(10'h050, 3, 16'h0400, 10'h150, 16'h0500);
    fill(10'h070, 2, 16'h0300, 10'h170, 16'h0300);

    #3;
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_addr", {act_addr, wgt_addr}, 0);
    check("rst_res_data", res_data, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);

    issue(4, 10'h010, 10'h100, 16'h0018, 1);
    wait_idle();
    issue(0, 10'h020, 10'h120, 16'h0000, 1);
    wait_idle();
    issue(4, 10'h3FE, 10'h200, 16'h0004, 1);
    wait_idle();

    res_ready = 1'b0;
    issue(2, 10'h040, 10'h140, 16'h0014, 1);
    for (int i = 0; i < 300 && !res_valid; i++) begin
      @(posedge clk); #2;
    end
    check("wait_res_valid", res_valid, 1);
    repeat (5) begin
      @(posedge clk); #2;
    end
    res_ready = 1'b1;
    start = 1'b1;
    len = 10'd3;
    act_base = 10'h050;
    wgt_base = 10'h150;
    push_job(3, 10'h050, 10'h150, 16'h003C, 1);
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b_fetch_rd_en", rd_en, 1);
    check("b2b_fetch_addr", act_addr, 10'h050);
    wait_idle();

    issue(8, 10'h060, 10'h160, 16'h0000, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_mac_out_en", mac_output_en, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_err", err, 0);
    check("arst_addr", {act_addr, wgt_addr}, 0);
    check("arst_mac_ab", {mac_a, mac_b}, 0);
    check("arst_res_data", res_data, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(2, 10'h070, 10'h170, 16'h0012, 1);
    wait_idle();

    issue(4, 10'h010, 10'h100, 16'h0018, 1);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("err_after_pulse", err, ERR_EXP);
    wait_idle();
    repeat (2) @(posedge clk);
    #2;
    check("err_sticky", err, ERR_EXP);
    check("results_left", res_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
